// File: rtl/stopwatch_timer.sv
// stopwatch_timer: single-clock BCD mm:ss.mmm stopwatch/countdown with ms prescaler.
// Optional lap capture enabled by defining STOPWATCH_LAP_EN.
module stopwatch_timer #(
  parameter int TICK_DIV = 50000,
  parameter int MIN_DIGITS = 2,
  localparam int W = 4*(MIN_DIGITS+5)
) (
  input  logic         clk_50Mhz,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         load,
  input  logic         dir,
  input  logic [W-1:0] preset,
  input  logic         lap,
  output logic [W-1:0] time_bcd,
  output logic [W-1:0] lap_bcd,
  output logic         lap_valid,
  output logic         running,
  output logic         done,
  output logic         tick
);
  localparam int N = MIN_DIGITS + 5;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic dir_q, itick, hit_zero, zstart;
  logic [W-1:0] up_v, dn_v, clean, nxt, live;
  logic [N-1:0] cy, bw;
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  // per-digit ripple of carry/borrow enables; digit 4 (sec1) is modulo 6
  for (genvar i = 0; i < N; i++) begin : g_dig
    localparam logic [3:0] MX = (i == 4) ? 4'd5 : 4'd9;
    logic [3:0] d, p;
    assign d = time_bcd[4*i +: 4];
    assign p = preset[4*i +: 4];
    assign up_v[4*i +: 4] = cy[i] ? ((d == MX) ? 4'd0 : d + 4'd1) : d;
    assign dn_v[4*i +: 4] = bw[i] ? ((d == 4'd0) ? MX : d - 4'd1) : d;
    assign clean[4*i +: 4] = (p > MX) ? 4'd0 : p;
    if (i < N-1) begin : g_c
      assign cy[i+1] = cy[i] && (d == MX);
      assign bw[i+1] = bw[i] && (d == 4'd0);
    end
  end
  assign itick = (state == RUN) && (presc == PMAX);
  assign nxt = dir_q ? dn_v : up_v;
  assign live = itick ? nxt : time_bcd;
  assign hit_zero = itick && dir_q && (nxt == '0);
  assign zstart = dir && (time_bcd == '0);
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      dir_q <= 1'b0;
      time_bcd <= '0;
      running <= 1'b0;
      done <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= itick && !load;
      if (load) begin
        state <= IDLE;
        running <= 1'b0;
        time_bcd <= clean;
        presc <= '0;
        done <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            dir_q <= dir;
            state <= zstart ? DONE : RUN;
            running <= !zstart;
            done <= zstart;
            presc <= '0;
          end
          RUN: begin
            time_bcd <= live;
            presc <= itick ? '0 : presc + 1'b1;
            if (hit_zero) begin
              state <= DONE;
              running <= 1'b0;
              done <= 1'b1;
            end else if (pause) begin
              state <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: if (start) begin
            state <= RUN;
            running <= 1'b1;
          end
          default: time_bcd <= '0;
        endcase
      end
    end
  end
`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      lap_bcd <= '0;
      lap_valid <= 1'b0;
    end else if (load) begin
      lap_valid <= 1'b0;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      lap_bcd <= live;
      lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd = '0;
  assign lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: directed + randomized checks against a millisecond-count reference model.
module tb_stopwatch_timer;
  localparam int TD = 4;
  localparam int MD = 2;
  localparam int NDIG = MD + 5;
  localparam int W = 4*NDIG;
  localparam int MAXT = 6000000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  logic clk_50Mhz = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pause = 1'b0, load = 1'b0, dir = 1'b0, lap = 1'b0;
  logic [W-1:0] preset = '0;
  logic [W-1:0] time_bcd, lap_bcd;
  logic lap_valid, running, done, tick;
  int checks = 0, errors = 0;
  int mt, mphase, mmode, mdir, mdone, mtick, mlap, mlv;
  int r;

  always #5 clk_50Mhz = ~clk_50Mhz;

  stopwatch_timer #(.TICK_DIV(TD), .MIN_DIGITS(MD)) dut (
    .clk_50Mhz(clk_50Mhz), .rst(rst), .start(start), .pause(pause), .load(load),
    .dir(dir), .preset(preset), .lap(lap), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
    .lap_valid(lap_valid), .running(running), .done(done), .tick(tick)
  );

  // sanitised preset as a total millisecond count
  function automatic int dec(input logic [W-1:0] p);
    int v, wgt, d, mx;
    v = 0;
    wgt = 1;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(p[4*i +: 4]);
      mx = (i == 4) ? 5 : 9;
      if (d <= mx) v += d * wgt;
      wgt = (i == 4) ? 60000 : wgt * 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] bcd(input int t);
    logic [W-1:0] b;
    int m, s, ms;
    m = t / 60000;
    s = (t / 1000) % 60;
    ms = t % 1000;
    b = '0;
    b[3:0] = 4'(ms % 10);
    b[7:4] = 4'((ms / 10) % 10);
    b[11:8] = 4'(ms / 100);
    b[15:12] = 4'(s % 10);
    b[19:16] = 4'(s / 10);
    for (int k = 0; k < MD; k++) begin
      b[4*(5+k) +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mt = 0; mphase = 0; mmode = 0; mdir = 0; mdone = 0; mtick = 0; mlap = 0; mlv = 0;
  endtask

  task automatic model_step();
    mtick = 0;
    if (load) begin
      mt = dec(preset); mmode = 0; mphase = 0; mdone = 0; mlv = 0;
    end else if (mmode == 0) begin
      if (start) begin
        mdir = int'(dir);
        if (dir && mt == 0) begin mmode = 3; mdone = 1; end
        else mmode = 1;
      end
    end else if (mmode == 1) begin
      mphase++;
      if (mphase == TD) begin
        mphase = 0;
        mtick = 1;
        mt = (mdir != 0) ? mt - 1 : (mt + 1) % MAXT;
        if (mdir != 0 && mt == 0) begin mmode = 3; mdone = 1; end
      end
      if (LAP && lap) begin mlap = mt; mlv = 1; end
      if (mmode == 1 && pause) mmode = 2;
    end else if (mmode == 2) begin
      if (LAP && lap) begin mlap = mt; mlv = 1; end
      if (start) mmode = 1;
    end
  endtask

  task automatic check_all();
    chk("time_bcd", 32'(time_bcd), 32'(bcd(mt)));
    chk("tick", 32'(tick), 32'(mtick));
    chk("done", 32'(done), 32'(mdone));
    chk("running", 32'(running), 32'(mmode == 1));
    chk("lap_bcd", 32'(lap_bcd), 32'(bcd(mlap)));
    chk("lap_valid", 32'(lap_valid), 32'(mlv));
  endtask

  task automatic cyc(input bit s, input bit p, input bit l, input bit lp);
    @(negedge clk_50Mhz);
    start = s; pause = p; load = l; lap = lp;
    model_step();
    @(posedge clk_50Mhz);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    preset = v;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_50Mhz);
    #1;
    check_all();
    @(negedge clk_50Mhz) rst = 1'b0;
    // up count: first update TICK_DIV edges after start
    dir = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("first_pre", 32'(time_bcd), 32'h0);
    idle(1);
    chk("first_tick", 32'(time_bcd), 32'h1);
    chk("first_tick_pulse", 32'(tick), 32'h1);
    idle(1);
    chk("tick_one_cycle", 32'(tick), 32'h0);
    // minute rollover
    do_load(28'h0059999);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("minute_roll", 32'(time_bcd), 32'h0100000);
    // wrap at maximum
    do_load(28'h9959999);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("wrap_time", 32'(time_bcd), 32'h0);
    chk("wrap_running", 32'(running), 32'h1);
    chk("wrap_done", 32'(done), 32'h0);
    // countdown to zero
    do_load(28'h0000003);
    dir = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    chk("cd_time", 32'(time_bcd), 32'h0);
    chk("cd_done", 32'(done), 32'h1);
    chk("cd_running", 32'(running), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("cd_start_ignored", 32'(running), 32'h0);
    do_load(28'h0);
    chk("cd_load_clears", 32'(done), 32'h0);
    // zero countdown: immediate done, no tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_notick", 32'(tick), 32'h0);
    // sanitising: sec1=A and ms2=F become 0
    dir = 1'b0;
    do_load(28'h00A7F12);
    chk("sanitise", 32'(time_bcd), 32'h0007012);
    // pause preserves prescaler phase
    do_load(28'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    chk("pause_hold", 32'(time_bcd), 32'h1);
    chk("pause_running", 32'(running), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("resume_early", 32'(time_bcd), 32'h1);
    idle(1);
    chk("resume_phase", 32'(time_bcd), 32'h2);
    // load > pause > start
    preset = 28'h0000500;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_time", 32'(time_bcd), 32'h500);
    chk("prio_idle", 32'(running), 32'h0);
    idle(5);
    chk("prio_stays_idle", 32'(time_bcd), 32'h500);
    // asynchronous reset mid-run
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    #2 rst = 1'b1;
    #1;
    chk("arst_time", 32'(time_bcd), 32'h0);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_lap", 32'(lap_bcd), 32'h0);
    model_reset();
    @(negedge clk_50Mhz) rst = 1'b0;
    idle(1);
    // lap capture
    do_load(28'h0001233);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_bcd", 32'(lap_bcd), LAP ? 32'h0001234 : 32'h0);
    chk("lap_valid", 32'(lap_valid), LAP ? 32'h1 : 32'h0);
    idle(4);
    chk("lap_keeps_counting", 32'(time_bcd), 32'h0001235);
    // randomized commands against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      dir = 1'($urandom_range(0, 1));
      preset = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 255));
      cyc(r < 10, r >= 10 && r < 16, r >= 16 && r < 19, $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
